// File: rtl/item_pool_if.sv
// item_pool_if: map-write, player-position and item-status signals of item_pool.
// Signalling: this bus has no valid/ready backpressure. Every input is sampled on
// each clk edge. we_in and tick are single-cycle strobes qualified only by
// themselves. p1_pickup, p2_pickup and spawn_dropped are single-cycle pulses that
// the consumer must catch while they are high. The pickup type fields carry
// meaning only in the cycle their pulse is high.
interface item_pool_if #(
    parameter int ADDR_WIDTH    = 8,
    parameter int MAP_MEM_WIDTH = 2,
    parameter int NUM_SLOTS     = 4,
    parameter int TYPE_W        = 2
);
    logic                          tick;
    logic                          game_over;
    logic                          we_in;
    logic [ADDR_WIDTH-1:0]         write_addr_in;
    logic [MAP_MEM_WIDTH-1:0]      write_data_in;
    logic                          gen_item;
    logic [TYPE_W-1:0]             type_rand;
    logic [2*ADDR_WIDTH-1:0]       p1_blk_addr;
    logic [2*ADDR_WIDTH-1:0]       p2_blk_addr;
    logic [NUM_SLOTS-1:0]          item_valid;
    logic [NUM_SLOTS*ADDR_WIDTH-1:0] item_addr;
    logic [NUM_SLOTS*TYPE_W-1:0]   item_type;
    logic                          p1_pickup;
    logic [TYPE_W-1:0]             p1_pickup_type;
    logic                          p2_pickup;
    logic [TYPE_W-1:0]             p2_pickup_type;
    logic                          spawn_dropped;

    modport master (
        output tick, game_over, we_in, write_addr_in, write_data_in, gen_item,
               type_rand, p1_blk_addr, p2_blk_addr,
        input  item_valid, item_addr, item_type, p1_pickup, p1_pickup_type,
               p2_pickup, p2_pickup_type, spawn_dropped
    );

    modport slave (
        input  tick, game_over, we_in, write_addr_in, write_data_in, gen_item,
               type_rand, p1_blk_addr, p2_blk_addr,
        output item_valid, item_addr, item_type, p1_pickup, p1_pickup_type,
               p2_pickup, p2_pickup_type, spawn_dropped
    );
endinterface

// File: rtl/item_pool.sv
// item_pool: keeps up to NUM_SLOTS power-up items on the map. Items spawn on
// freed blocks, expire after ITEM_TIME seconds of ticks, and are collected by
// players standing on them. Every output is a register; item_valid is the
// per-slot FREE/ACTIVE state itself.
module item_pool #(
    parameter int NUM_ROW       = 11,
    parameter int NUM_COL       = 15,
    parameter int MAP_MEM_WIDTH = 2,
    parameter int NUM_SLOTS     = 4,
    parameter int NUM_TYPES     = 3,
    parameter int ITEM_TIME     = 8,
    parameter int TICKS_PER_SEC = 60
) (
    input logic       clk,
    input logic       rst_n,
    item_pool_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL);
    localparam int TYPE_W     = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1;
    localparam int SEC_W      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int CNT_W      = $clog2(ITEM_TIME + 1);

    localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ITEM_TIME);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TYPE_W:0]   TYPE_LIM = (TYPE_W + 1)'(NUM_TYPES);

    typedef enum logic {FREE = 1'b0, ACTIVE = 1'b1} slot_state_t;

    slot_state_t             state_q [NUM_SLOTS];
    slot_state_t             state_d [NUM_SLOTS];
    logic [ADDR_WIDTH-1:0]   addr_q  [NUM_SLOTS];
    logic [ADDR_WIDTH-1:0]   addr_d  [NUM_SLOTS];
    logic [TYPE_W-1:0]       type_q  [NUM_SLOTS];
    logic [TYPE_W-1:0]       type_d  [NUM_SLOTS];
    logic [SEC_W-1:0]        sec_q   [NUM_SLOTS];
    logic [SEC_W-1:0]        sec_d   [NUM_SLOTS];
    logic [CNT_W-1:0]        cnt_q   [NUM_SLOTS];
    logic [CNT_W-1:0]        cnt_d   [NUM_SLOTS];

    logic                    p1_pk_q, p1_pk_d, p2_pk_q, p2_pk_d, drop_q, drop_d;
    logic [TYPE_W-1:0]       p1_ty_q, p1_ty_d, p2_ty_q, p2_ty_d;

    logic                    spawn_req, dup_hit;
    logic [TYPE_W-1:0]       spawn_type;
    logic [NUM_SLOTS-1:0]    free_oh, alloc_oh, p1_oh, p2_oh;
    logic [ADDR_WIDTH-1:0]   p1_b1, p1_b2, p2_b1, p2_b2;

    logic [NUM_SLOTS-1:0]            valid_vec;
    logic [NUM_SLOTS*ADDR_WIDTH-1:0] addr_vec;
    logic [NUM_SLOTS*TYPE_W-1:0]     type_vec;

    assign p1_b1 = bus.p1_blk_addr[ADDR_WIDTH-1:0];
    assign p1_b2 = bus.p1_blk_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign p2_b1 = bus.p2_blk_addr[ADDR_WIDTH-1:0];
    assign p2_b2 = bus.p2_blk_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];

    // Next-state: arbitration of spawn/pickup on pre-edge slot state, then per-slot FSM and timers.
    always_comb begin
        spawn_req  = bus.we_in && (bus.write_data_in == '0) && bus.gen_item && !bus.game_over;
        spawn_type = ({1'b0, bus.type_rand} >= TYPE_LIM) ? '0 : bus.type_rand;
        dup_hit    = 1'b0;
        free_oh    = '0;
        p1_oh      = '0;
        p2_oh      = '0;
        p1_ty_d    = '0;
        p2_ty_d    = '0;

        // Lowest-index free slot and duplicate-address detection; slots freed
        // this cycle still look ACTIVE, so they cannot be reused until next edge.
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (state_q[s] == ACTIVE && addr_q[s] == bus.write_addr_in) dup_hit = 1'b1;
            if (state_q[s] == FREE && free_oh == '0) free_oh[s] = 1'b1;
        end
        alloc_oh = (spawn_req && !dup_hit) ? free_oh : '0;
        drop_d   = spawn_req && !dup_hit && (free_oh == '0);

        // Player 1 wins a shared slot; player 2 then takes its own next match.
        if (!bus.game_over) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (state_q[s] == ACTIVE && (addr_q[s] == p1_b1 || addr_q[s] == p1_b2)
                    && p1_oh == '0) p1_oh[s] = 1'b1;
            end
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (state_q[s] == ACTIVE && (addr_q[s] == p2_b1 || addr_q[s] == p2_b2)
                    && !p1_oh[s] && p2_oh == '0) p2_oh[s] = 1'b1;
            end
        end
        p1_pk_d = |p1_oh;
        p2_pk_d = |p2_oh;

        for (int s = 0; s < NUM_SLOTS; s++) begin
            state_d[s] = state_q[s];
            addr_d[s]  = addr_q[s];
            type_d[s]  = type_q[s];
            sec_d[s]   = sec_q[s];
            cnt_d[s]   = cnt_q[s];
            if (p1_oh[s]) p1_ty_d = type_q[s];
            if (p2_oh[s]) p2_ty_d = type_q[s];

            if (bus.game_over) begin
                state_d[s] = FREE;
                sec_d[s]   = '0;
                cnt_d[s]   = '0;
            end else if (state_q[s] == ACTIVE) begin
                // Pickup takes priority over an expiry landing on the same edge.
                if (p1_oh[s] || p2_oh[s]) begin
                    state_d[s] = FREE;
                    sec_d[s]   = '0;
                    cnt_d[s]   = '0;
                end else if (bus.tick) begin
                    if (sec_q[s] == SEC_MAX) begin
                        sec_d[s] = '0;
                        if (cnt_q[s] == CNT_ONE) begin
                            state_d[s] = FREE;
                            cnt_d[s]   = '0;
                        end else begin
                            cnt_d[s] = cnt_q[s] - 1'b1;
                        end
                    end else begin
                        sec_d[s] = sec_q[s] + 1'b1;
                    end
                end
            end else if (alloc_oh[s]) begin
                state_d[s] = ACTIVE;
                addr_d[s]  = bus.write_addr_in;
                type_d[s]  = spawn_type;
                sec_d[s]   = '0;
                cnt_d[s]   = CNT_LOAD;
            end
        end
    end

    // State register: slots, timers and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s] <= FREE;
                addr_q[s]  <= '0;
                type_q[s]  <= '0;
                sec_q[s]   <= '0;
                cnt_q[s]   <= '0;
            end
            p1_pk_q <= 1'b0;
            p2_pk_q <= 1'b0;
            drop_q  <= 1'b0;
            p1_ty_q <= '0;
            p2_ty_q <= '0;
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s] <= state_d[s];
                addr_q[s]  <= addr_d[s];
                type_q[s]  <= type_d[s];
                sec_q[s]   <= sec_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
            p1_pk_q <= p1_pk_d;
            p2_pk_q <= p2_pk_d;
            drop_q  <= drop_d;
            p1_ty_q <= p1_ty_d;
            p2_ty_q <= p2_ty_d;
        end
    end

    // Pack per-slot registers onto the flat output buses.
    always_comb begin
        valid_vec = '0;
        addr_vec  = '0;
        type_vec  = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            valid_vec[s]                           = (state_q[s] == ACTIVE);
            addr_vec[s*ADDR_WIDTH +: ADDR_WIDTH]   = addr_q[s];
            type_vec[s*TYPE_W +: TYPE_W]           = type_q[s];
        end
    end

    assign bus.item_valid     = valid_vec;
    assign bus.item_addr      = addr_vec;
    assign bus.item_type      = type_vec;
    assign bus.p1_pickup      = p1_pk_q;
    assign bus.p1_pickup_type = p1_ty_q;
    assign bus.p2_pickup      = p2_pk_q;
    assign bus.p2_pickup_type = p2_ty_q;
    assign bus.spawn_dropped  = drop_q;
endmodule

// File: tb/tb_item_pool.sv
// tb_item_pool: table vectors, hand-written race sequences and random traffic
// for item_pool, checked against a lifetime-in-ticks reference model.
module tb_item_pool;
    localparam int NS   = 4;
    localparam int AW   = 8;
    localparam int MW   = 2;
    localparam int TW   = 2;
    localparam int NT   = 3;
    localparam int LIFE = 8 * 60;
    localparam int NOWHERE = 250;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // clock and reset
    always #5 clk = ~clk;

    item_pool_if #(.ADDR_WIDTH(AW), .MAP_MEM_WIDTH(MW), .NUM_SLOTS(NS), .TYPE_W(TW)) bus();

    item_pool #(
        .NUM_ROW(11), .NUM_COL(15), .MAP_MEM_WIDTH(MW), .NUM_SLOTS(NS),
        .NUM_TYPES(NT), .ITEM_TIME(8), .TICKS_PER_SEC(60)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // reference model: each item has a remaining lifetime counted in ticks
    bit m_act [NS];
    int m_addr[NS];
    int m_type[NS];
    int m_left[NS];
    bit e_p1, e_p2, e_drop;
    int e_p1t, e_p2t;

    typedef struct {
        bit we; int data; bit gen; int addr; int trand;
        int p1a; int p1b; int p2a; int p2b; bit go;
        int e_valid; bit e_drop; bit e_p1; int e_p1t; bit e_p2; int e_p2t;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_act[s] = 0; m_addr[s] = 0; m_type[s] = 0; m_left[s] = 0;
        end
        e_p1 = 0; e_p2 = 0; e_drop = 0; e_p1t = 0; e_p2t = 0;
    endtask

    function automatic bit on_item(int a, logic [2*AW-1:0] blks);
        return a == int'(blks[AW-1:0]) || a == int'(blks[2*AW-1:AW]);
    endfunction

    task automatic model_step();
        int p1s, p2s, fs, wa, tr;
        bit dup, req;
        e_p1 = 0; e_p2 = 0; e_drop = 0; e_p1t = 0; e_p2t = 0;
        if (bus.game_over) begin
            for (int s = 0; s < NS; s++) m_act[s] = 0;
            return;
        end
        p1s = -1; p2s = -1; fs = -1; dup = 0;
        wa = int'(bus.write_addr_in);
        tr = int'(bus.type_rand);
        for (int s = 0; s < NS; s++)
            if (p1s < 0 && m_act[s] && on_item(m_addr[s], bus.p1_blk_addr)) p1s = s;
        for (int s = 0; s < NS; s++)
            if (p2s < 0 && s != p1s && m_act[s] && on_item(m_addr[s], bus.p2_blk_addr)) p2s = s;
        req = bus.we_in && bus.write_data_in == 0 && bus.gen_item;
        for (int s = 0; s < NS; s++) begin
            if (m_act[s] && m_addr[s] == wa) dup = 1;
            if (!m_act[s] && fs < 0) fs = s;
        end
        if (p1s >= 0) begin e_p1 = 1; e_p1t = m_type[p1s]; m_act[p1s] = 0; end
        if (p2s >= 0) begin e_p2 = 1; e_p2t = m_type[p2s]; m_act[p2s] = 0; end
        if (bus.tick)
            for (int s = 0; s < NS; s++)
                if (m_act[s]) begin
                    m_left[s]--;
                    if (m_left[s] == 0) m_act[s] = 0;
                end
        if (req && !dup) begin
            if (fs < 0) e_drop = 1;
            else begin
                m_act[fs] = 1; m_addr[fs] = wa;
                m_type[fs] = (tr >= NT) ? 0 : tr;
                m_left[fs] = LIFE;
            end
        end
    endtask

    task automatic check_model(string tag);
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("%s valid[%0d]", tag, s), int'(bus.item_valid[s]), int'(m_act[s]));
            if (m_act[s]) begin
                chk($sformatf("%s addr[%0d]", tag, s), int'(bus.item_addr[s*AW +: AW]), m_addr[s]);
                chk($sformatf("%s type[%0d]", tag, s), int'(bus.item_type[s*TW +: TW]), m_type[s]);
            end
        end
        chk({tag, " drop"}, int'(bus.spawn_dropped), int'(e_drop));
        chk({tag, " p1"}, int'(bus.p1_pickup), int'(e_p1));
        chk({tag, " p2"}, int'(bus.p2_pickup), int'(e_p2));
        if (e_p1) chk({tag, " p1type"}, int'(bus.p1_pickup_type), e_p1t);
        if (e_p2) chk({tag, " p2type"}, int'(bus.p2_pickup_type), e_p2t);
    endtask

    // driver tasks
    task automatic idle();
        bus.tick = 0; bus.game_over = 0; bus.we_in = 0; bus.write_addr_in = '0;
        bus.write_data_in = '0; bus.gen_item = 0; bus.type_rand = '0;
        bus.p1_blk_addr = {AW'(NOWHERE), AW'(NOWHERE)};
        bus.p2_blk_addr = {AW'(NOWHERE), AW'(NOWHERE)};
    endtask

    task automatic spawn_in(int a, int t);
        bus.we_in = 1; bus.write_data_in = '0; bus.gen_item = 1;
        bus.write_addr_in = AW'(a); bus.type_rand = TW'(t);
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    function automatic vec_t mk(bit we, int data, bit gen, int addr, int trand,
                                int p1a, int p1b, int p2a, int p2b, bit go,
                                int ev, bit ed, bit ep1, int ep1t, bit ep2, int ep2t);
        vec_t v;
        v.we = we; v.data = data; v.gen = gen; v.addr = addr; v.trand = trand;
        v.p1a = p1a; v.p1b = p1b; v.p2a = p2a; v.p2b = p2b; v.go = go;
        v.e_valid = ev; v.e_drop = ed; v.e_p1 = ep1; v.e_p1t = ep1t; v.e_p2 = ep2; v.e_p2t = ep2t;
        return v;
    endfunction

    initial begin
        localparam int N = NOWHERE;
        vecs.push_back(mk(1,0,1,17,2, N,N,N,N,0, 4'b0001,0,0,0,0,0)); // spawn 17 type 2
        vecs.push_back(mk(1,0,0,30,1, N,N,N,N,0, 4'b0001,0,0,0,0,0)); // gen_item low
        vecs.push_back(mk(1,1,1,31,1, N,N,N,N,0, 4'b0001,0,0,0,0,0)); // block not freed
        vecs.push_back(mk(1,0,1, 3,1, N,N,N,N,0, 4'b0011,0,0,0,0,0));
        vecs.push_back(mk(1,0,1, 5,0, N,N,N,N,0, 4'b0111,0,0,0,0,0));
        vecs.push_back(mk(1,0,1, 7,2, N,N,N,N,0, 4'b1111,0,0,0,0,0));
        vecs.push_back(mk(1,0,1, 9,1, N,N,N,N,0, 4'b1111,1,0,0,0,0)); // pool full
        vecs.push_back(mk(1,0,1, 3,1, N,N,N,N,0, 4'b1111,0,0,0,0,0)); // duplicate
        vecs.push_back(mk(0,0,0, 0,0,17,N,N,N,0, 4'b1110,0,1,2,0,0)); // p1 blk1
        vecs.push_back(mk(0,0,0, 0,0, N,3,3,N,0, 4'b1100,0,1,1,0,0)); // shared: p1 wins
        vecs.push_back(mk(1,0,1,20,1, N,N,N,N,0, 4'b1101,0,0,0,0,0)); // reuse slot 0
        vecs.push_back(mk(0,0,0, 0,0,20,N,20,5,0, 4'b1000,0,1,1,1,0)); // p2 takes other match
        vecs.push_back(mk(1,0,1,40,3, N,N,N,N,0, 4'b1001,0,0,0,0,0)); // type 3 -> 0
        vecs.push_back(mk(0,0,0, 0,0, N,N,N,40,0, 4'b1000,0,0,0,1,0));
        vecs.push_back(mk(1,0,1,50,1, 7,N,N,N,1, 4'b0000,0,0,0,0,0)); // game_over
        vecs.push_back(mk(0,0,0, 0,0, N,N,N,N,0, 4'b0000,0,0,0,0,0));

        idle();
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset valid", int'(bus.item_valid), 0);
        chk("reset addr", int'(bus.item_addr), 0);
        chk("reset pulses", int'({bus.p1_pickup, bus.p2_pickup, bus.spawn_dropped}), 0);
        rst_n = 1'b1;

        // table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            idle();
            bus.we_in = v.we; bus.write_data_in = MW'(v.data); bus.gen_item = v.gen;
            bus.write_addr_in = AW'(v.addr); bus.type_rand = TW'(v.trand);
            bus.p1_blk_addr = {AW'(v.p1b), AW'(v.p1a)};
            bus.p2_blk_addr = {AW'(v.p2b), AW'(v.p2a)};
            bus.game_over = v.go;
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d valid", i), int'(bus.item_valid), v.e_valid);
            chk($sformatf("vec%0d drop", i), int'(bus.spawn_dropped), int'(v.e_drop));
            chk($sformatf("vec%0d p1", i), int'(bus.p1_pickup), int'(v.e_p1));
            chk($sformatf("vec%0d p2", i), int'(bus.p2_pickup), int'(v.e_p2));
            if (v.e_p1) chk($sformatf("vec%0d p1type", i), int'(bus.p1_pickup_type), v.e_p1t);
            if (v.e_p2) chk($sformatf("vec%0d p2type", i), int'(bus.p2_pickup_type), v.e_p2t);
        end

        // expiry boundary: alive after 479 ticks, gone on the 480th
        idle(); spawn_in(60, 1); step("exp spawn");
        idle(); bus.tick = 1;
        for (int i = 0; i < LIFE - 1; i++) step("exp run");
        chk("exp 479 ticks", int'(bus.item_valid[0]), 1);
        step("exp last");
        chk("exp 480 ticks", int'(bus.item_valid[0]), 0);

        // pickup on the expiring tick still reports the pickup
        idle(); spawn_in(70, 2); step("race spawn");
        idle(); bus.tick = 1;
        for (int i = 0; i < LIFE - 1; i++) step("race run");
        bus.p1_blk_addr = {AW'(NOWHERE), AW'(70)};
        step("race pick");
        chk("race p1 pulse", int'(bus.p1_pickup), 1);
        chk("race p1 type", int'(bus.p1_pickup_type), 2);
        chk("race valid", int'(bus.item_valid[0]), 0);

        // spawn while full and a slot frees on the same edge is dropped
        for (int i = 0; i < NS; i++) begin
            idle(); spawn_in(80 + i, i % NT); step("full fill");
        end
        idle(); spawn_in(84, 1); bus.p1_blk_addr = {AW'(NOWHERE), AW'(81)};
        step("full race");
        chk("full race drop", int'(bus.spawn_dropped), 1);
        chk("full race valid", int'(bus.item_valid), 4'b1101);
        idle(); spawn_in(84, 1); step("full retry");
        chk("full retry valid", int'(bus.item_valid), 4'b1111);
        chk("full retry addr1", int'(bus.item_addr[AW +: AW]), 84);

        // game_over with three live items, one under a player
        idle(); bus.game_over = 1; step("go clear");
        for (int i = 0; i < 3; i++) begin
            idle(); spawn_in(90 + i, 1); step("go fill");
        end
        chk("go fill valid", int'(bus.item_valid), 4'b0111);
        idle(); bus.game_over = 1; bus.p1_blk_addr = {AW'(NOWHERE), AW'(90)};
        step("go");
        chk("go valid", int'(bus.item_valid), 0);
        chk("go pulses", int'({bus.p1_pickup, bus.p2_pickup, bus.spawn_dropped}), 0);

        // asynchronous reset mid-countdown
        idle(); spawn_in(100, 2); step("rst spawn");
        idle(); bus.tick = 1;
        for (int i = 0; i < 100; i++) step("rst run");
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("async rst valid", int'(bus.item_valid), 0);
        chk("async rst addr", int'(bus.item_addr), 0);
        chk("async rst type", int'(bus.item_type), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            idle();
            bus.tick = ($urandom_range(0, 3) != 0);
            bus.we_in = $urandom_range(0, 1);
            bus.write_data_in = ($urandom_range(0, 3) == 0) ? MW'($urandom_range(1, 3)) : '0;
            bus.gen_item = $urandom_range(0, 1);
            bus.write_addr_in = AW'($urandom_range(0, 15));
            bus.type_rand = TW'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bus.p1_blk_addr[AW-1:0] = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bus.p1_blk_addr[2*AW-1:AW] = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bus.p2_blk_addr[AW-1:0] = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bus.p2_blk_addr[2*AW-1:AW] = AW'($urandom_range(0, 15));
            bus.game_over = ($urandom_range(0, 499) == 0);
            step("rand");
        end

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
